tap_window_gen: RTL and testbench

Vertical 5-tap window generator for the HDMI convolution filter path. Accepts a raster pixel stream, stores the four previous lines in on-chip line memories and presents five vertically aligned pixels (rows r-4 … r) on `pa`..`pe`. These are exactly the operand ports of `dsp_cascade`. It is the producer side of the cascade's tap interface and sits between the HDMI input pixel stream and the filter.

---
 rtl/filt_pkg.sv | 31 +++
 rtl/line_mem.sv | 38 +++
 rtl/tap_window_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_tap_window_gen.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared pixel/tap definitions for the HDMI convolution filter path.
// Also imported by dsp_cascade, which consumes the five taps.
package filt_pkg;

  localparam int PIX_W   = 8;
  localparam int N_TAPS  = 5;
  localparam int ROW_MAX = 4;

  typedef logic [PIX_W-1:0] pix_t;

  // Tap bundle, a = oldest row (r-4) ... e = current row (r)
  typedef struct packed {
    pix_t a;
    pix_t b;
    pix_t c;
    pix_t d;
    pix_t e;
  } taps_t;

  // Row counter increment that sticks at ROW_MAX once full history exists
  function automatic logic [2:0] row_inc_sat(input logic [2:0] row);
    logic [2:0] nxt;
    if (row >= 3'(ROW_MAX)) begin
      nxt = 3'(ROW_MAX);
    end else begin
      nxt = row + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/line_mem.sv
// One line of pixel history: simple dual-port RAM with one synchronous
// read port and one write port. Contents are never reset so the array
// maps onto block RAM.
module line_mem
  import filt_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [PIX_W-1:0] rd_data_o,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [PIX_W-1:0] wr_data_i
);

  pix_t mem_q [DEPTH];
  pix_t rd_data_q;

  // Write port: store one pixel per enabled cycle
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port: registered read, old data returned on a same-address write
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tap_window_gen.sv
// Vertical 5-tap window generator. Keeps four previous lines in line_mem
// instances and presents rows r-4..r on pa..pe, two cycles after input.
// Optional feature macro: TAP_EDGE_REPLICATE_EN -- when defined, rows 0-3
// of a frame also produce output with missing history replaced by the
// oldest available row; when undefined, only rows with full history emit.
module tap_window_gen
  import filt_pkg::*;
#(
  parameter int LINE_W = 1024,
  parameter int COL_W  = $clog2(LINE_W)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pix,
  input  logic       in_sol,
  input  logic       in_sof,
  output logic [7:0] pa,
  output logic [7:0] pb,
  output logic [7:0] pc,
  output logic [7:0] pd,
  output logic [7:0] pe,
  output logic       out_valid,
  output logic       line_ovf
);

  localparam int              N_LINES  = N_TAPS - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

  // Input-side counters
  logic [COL_W-1:0] col_q, col_d;
  logic [2:0]       row_q, row_d;
  logic             line_ovf_q, line_ovf_d;

  // Stage 1 (pixel registered, memory read in flight)
  logic             s1_valid_q;
  pix_t             s1_pix_q;
  logic [COL_W-1:0] s1_col_q;
  logic [2:0]       s1_row_q;

  // Read-after-write forwarding for back-to-back same-address pixels
  logic             fwd_hit_s;
  logic             fwd_hit_q;
  pix_t             fwd_data_q [N_LINES];

  pix_t             rd_data_s [N_LINES];
  pix_t             rd_eff_s  [N_LINES];
  pix_t             wr_data_s [N_LINES];

  // Stage 2 (registered taps)
  taps_t            taps_s;
  logic             emit_s;
  taps_t            taps_q;
  logic             out_valid_q;

  // Next column, row and overflow state for the incoming pixel
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    line_ovf_d = line_ovf_q;
    if (in_valid) begin
      if (in_sof) begin
        col_d      = '0;
        row_d      = 3'd0;
        line_ovf_d = 1'b0;
      end else if (in_sol) begin
        col_d      = '0;
        row_d      = row_inc_sat(row_q);
      end else if (col_q == COL_LAST) begin
        // Too many pixels: keep overwriting the last address
        line_ovf_d = 1'b1;
      end else begin
        col_d      = col_q + COL_W'(1'b1);
      end
    end else begin
      col_d      = col_q;
      row_d      = row_q;
      line_ovf_d = line_ovf_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q      <= '0;
      row_q      <= 3'd0;
      line_ovf_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      line_ovf_q <= line_ovf_d;
    end
  end

  // Stage 1 pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_pix_q   <= '0;
      s1_col_q   <= '0;
      s1_row_q   <= 3'd0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_pix_q <= in_pix;
        s1_col_q <= col_d;
        s1_row_q <= row_d;
      end
    end
  end

  // A new read colliding with this cycle's write would return stale data
  assign fwd_hit_s = in_valid & s1_valid_q & (col_d == s1_col_q);

  // Effective read data and the shifted write-back data
  always_comb begin
    for (int k = 0; k < N_LINES; k++) begin
      rd_eff_s[k] = fwd_hit_q ? fwd_data_q[k] : rd_data_s[k];
    end
    wr_data_s[0] = s1_pix_q;
    for (int k = 1; k < N_LINES; k++) begin
      wr_data_s[k] = rd_eff_s[k-1];
    end
  end

  // Capture write-back data for the next pixel when addresses collide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_hit_q <= 1'b0;
      for (int k = 0; k < N_LINES; k++) begin
        fwd_data_q[k] <= '0;
      end
    end else begin
      fwd_hit_q <= fwd_hit_s;
      if (in_valid) begin
        for (int k = 0; k < N_LINES; k++) begin
          fwd_data_q[k] <= wr_data_s[k];
        end
      end
    end
  end

  // Four line memories; Lk holds row r-1-k
  for (genvar g = 0; g < N_LINES; g++) begin : g_line
    line_mem #(
      .DEPTH (LINE_W),
      .AW    (COL_W)
    ) u_line_mem (
      .clk       (clk),
      .rd_en_i   (in_valid),
      .rd_addr_i (col_d),
      .rd_data_o (rd_data_s[g]),
      .wr_en_i   (s1_valid_q),
      .wr_addr_i (s1_col_q),
      .wr_data_i (wr_data_s[g])
    );
  end

  // Tap selection and output gating by row history
  always_comb begin
    taps_s.e = s1_pix_q;
    taps_s.d = rd_eff_s[0];
    taps_s.c = rd_eff_s[1];
    taps_s.b = rd_eff_s[2];
    taps_s.a = rd_eff_s[3];
    emit_s   = 1'b0;
`ifdef TAP_EDGE_REPLICATE_EN
    emit_s = s1_valid_q;
    case (s1_row_q)
      3'd0: begin
        taps_s.a = s1_pix_q;
        taps_s.b = s1_pix_q;
        taps_s.c = s1_pix_q;
        taps_s.d = s1_pix_q;
      end
      3'd1: begin
        taps_s.a = rd_eff_s[0];
        taps_s.b = rd_eff_s[0];
        taps_s.c = rd_eff_s[0];
      end
      3'd2: begin
        taps_s.a = rd_eff_s[1];
        taps_s.b = rd_eff_s[1];
      end
      3'd3: begin
        taps_s.a = rd_eff_s[2];
      end
      default: begin
        taps_s.a = rd_eff_s[3];
      end
    endcase
`else
    if (s1_valid_q && (s1_row_q == 3'd4)) begin
      emit_s = 1'b1;
    end else begin
      emit_s = 1'b0;
    end
`endif
  end

  // Stage 2 output registers; taps hold when nothing is emitted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      taps_q      <= '0;
    end else begin
      out_valid_q <= emit_s;
      if (emit_s) begin
        taps_q <= taps_s;
      end
    end
  end

  assign pa        = taps_q.a;
  assign pb        = taps_q.b;
  assign pc        = taps_q.c;
  assign pd        = taps_q.d;
  assign pe        = taps_q.e;
  assign out_valid = out_valid_q;
  assign line_ovf  = line_ovf_q;

endmodule

// File: tb/tb_tap_window_gen.sv
// Directed bench for tap_window_gen with LINE_W=8. Expected tap values are
// derived from the raster pattern pixel = row*16 + col.
module tb_tap_window_gen;

  localparam int LW = 8;
`ifdef TAP_EDGE_REPLICATE_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_pix = 8'h00;
  logic       in_sol = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] pa, pb, pc, pd, pe;
  logic       out_valid, line_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [39:0] taps;
  } ev_t;

  ev_t cap_q[$];
  ev_t exp_q[$];

  tap_window_gen #(.LINE_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pix    (in_pix),
    .in_sol    (in_sol),
    .in_sof    (in_sof),
    .pa        (pa),
    .pb        (pb),
    .pc        (pc),
    .pd        (pd),
    .pe        (pe),
    .out_valid (out_valid),
    .line_ovf  (line_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every emitted tap set with the cycle it appeared in
  always @(negedge clk) begin
    ev_t ev;
    if (out_valid) begin
      ev.cyc  = cyc;
      ev.taps = {pa, pb, pc, pd, pe};
      cap_q.push_back(ev);
    end
  end

  function automatic logic [39:0] exp_taps(input int r, input int c);
    logic [39:0] v;
    int src;
    for (int j = 0; j < 5; j++) begin
      src = r - 4 + j;
      if (src < 0) src = 0;
      v[39-8*j -: 8] = 8'(src * 16 + c);
    end
    return v;
  endfunction

  task automatic drive(input bit v, input logic [7:0] p, input bit sol, input bit sof);
    in_valid = v;
    in_pix   = p;
    in_sol   = sol;
    in_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with junk markers that must be ignored
  task automatic idle();
    drive(1'b0, 8'($urandom), 1'b1, 1'($urandom));
  endtask

  task automatic send_frame(input int rows, input bit gaps);
    ev_t ev;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (gaps) begin
          for (int k = 0; k < 8 && $urandom_range(0, 1) == 0; k++) idle();
        end
        if (REP || r >= 4) begin
          ev.cyc  = cyc + 2;
          ev.taps = exp_taps(r, c);
          exp_q.push_back(ev);
        end
        drive(1'b1, 8'(r * 16 + c), c == 0, (r == 0) && (c == 0));
      end
    end
    repeat (4) idle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (pa !== 8'h00) begin n_fail++; $display("FAIL reset_pa: got %h expected 00", pa); end
    n_checks++; if (pb !== 8'h00) begin n_fail++; $display("FAIL reset_pb: got %h expected 00", pb); end
    n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", pc); end
    n_checks++; if (pd !== 8'h00) begin n_fail++; $display("FAIL reset_pd: got %h expected 00", pd); end
    n_checks++; if (pe !== 8'h00) begin n_fail++; $display("FAIL reset_pe: got %h expected 00", pe); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", line_ovf); end
    rst = 1'b1;
    repeat (2) idle();
  endtask

  task automatic test_stream(input bit gaps);
    string       nm;
    int          idx;
    logic [39:0] got;
    nm = gaps ? "gapped" : "steady";
    cap_q.delete();
    exp_q.delete();
    send_frame(6, gaps);
    n_checks++;
    if (cap_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count: got %0d expected %0d", nm, cap_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      n_checks++;
      if (cap_q[i].cyc !== exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL %s_latency[%0d]: got cycle %0d expected %0d", nm, i, cap_q[i].cyc, exp_q[i].cyc);
      end
      n_checks++;
      if (cap_q[i].taps !== exp_q[i].taps) begin
        n_fail++;
        $display("FAIL %s_taps[%0d]: got %h expected %h", nm, i, cap_q[i].taps, exp_q[i].taps);
      end
    end
    idx = REP ? 35 : 3;
    got = (idx < cap_q.size()) ? cap_q[idx].taps : 40'hxxxxxxxxxx;
    n_checks++;
    if (got !== 40'h0313233343) begin
      n_fail++;
      $display("FAIL %s_r4c3: got %h expected 0313233343", nm, got);
    end
`ifdef TAP_EDGE_REPLICATE_EN
    got = (cap_q.size() > 2) ? cap_q[2].taps : 40'hxxxxxxxxxx;
    n_checks++;
    if (got !== 40'h0202020202) begin
      n_fail++;
      $display("FAIL %s_rep_r0c2: got %h expected 0202020202", nm, got);
    end
    got = (cap_q.size() > 18) ? cap_q[18].taps : 40'hxxxxxxxxxx;
    n_checks++;
    if (got !== 40'h0202021222) begin
      n_fail++;
      $display("FAIL %s_rep_r2c2: got %h expected 0202021222", nm, got);
    end
`endif
  endtask

  task automatic test_one_px_lines();
    int          last_in;
    int          want_n;
    logic [39:0] got;
    int          got_cyc;
    cap_q.delete();
    for (int i = 1; i <= 5; i++) begin
      last_in = cyc;
      drive(1'b1, 8'(i), 1'b1, i == 1);
    end
    repeat (4) idle();
    want_n = REP ? 5 : 1;
    n_checks++;
    if (cap_q.size() !== want_n) begin
      n_fail++;
      $display("FAIL onepx_count: got %0d expected %0d", cap_q.size(), want_n);
    end
    got     = (cap_q.size() > 0) ? cap_q[cap_q.size()-1].taps : 40'hxxxxxxxxxx;
    got_cyc = (cap_q.size() > 0) ? cap_q[cap_q.size()-1].cyc : -1;
    n_checks++;
    if (got !== 40'h0102030405) begin
      n_fail++;
      $display("FAIL onepx_taps: got %h expected 0102030405", got);
    end
    n_checks++;
    if (got_cyc !== last_in + 2) begin
      n_fail++;
      $display("FAIL onepx_latency: got cycle %0d expected %0d", got_cyc, last_in + 2);
    end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 8'(c), c == 0, c == 0);
      if (c == 7) begin
        n_checks++;
        if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_8: got %b expected 0", line_ovf); end
      end
      if (c >= 8) begin
        n_checks++;
        if (line_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_px%0d: got %b expected 1", c + 1, line_ovf); end
      end
    end
    for (int c = 0; c < 3; c++) drive(1'b1, 8'(c), c == 0, 1'b0);
    n_checks++;
    if (line_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_next_line: got %b expected 1", line_ovf); end
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (line_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_invalid_sof: got %b expected 1", line_ovf); end
    drive(1'b1, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (line_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_sof: got %b expected 0", line_ovf); end
    repeat (3) idle();
  endtask

  task automatic test_reset_mid_frame();
    int          want_n;
    logic [39:0] got;
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < LW; c++) begin
        if (r == 5 && c == 4) break;
        drive(1'b1, 8'(r * 16 + c), c == 0, (r == 0) && (c == 0));
      end
    end
    #2;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    n_checks++;
    if ({pa, pb, pc, pd, pe} !== 40'h0) begin
      n_fail++;
      $display("FAIL midrst_taps: got %h expected 0000000000", {pa, pb, pc, pd, pe});
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    cap_q.delete();
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 8'h78, 1'b0, 1'b0);
    repeat (4) idle();
    want_n = REP ? 2 : 0;
    n_checks++;
    if (cap_q.size() !== want_n) begin
      n_fail++;
      $display("FAIL midrst_flush: got %0d outputs expected %0d", cap_q.size(), want_n);
    end
    cap_q.delete();
    exp_q.delete();
    send_frame(6, 1'b0);
    n_checks++;
    if (cap_q.size() !== exp_q.size()) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d expected %0d", cap_q.size(), exp_q.size());
    end
    got = (cap_q.size() > 0) ? cap_q[0].taps : 40'hxxxxxxxxxx;
    n_checks++;
    if (got !== (REP ? 40'h0000000000 : 40'h0010203040)) begin
      n_fail++;
      $display("FAIL midrst_first: got %h expected %h", got, REP ? 40'h0000000000 : 40'h0010203040);
    end
  endtask

  initial begin
    test_reset();
    test_stream(1'b0);
    test_stream(1'b1);
    test_one_px_lines();
    test_overflow();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
